// File: rtl/spi_pkg.sv
// Shared constants, state encoding and frame-field helpers for the SPI slave frame receiver.
// Field helpers are for the downstream command decoder.
package spi_pkg;

    localparam int unsigned FrameBitsDef = 32;

    // Mode 3: SCK idles high, data captured on the rising (trailing) edge.
    localparam logic SpiCpol = 1'b1;
    localparam logic SpiCpha = 1'b1;

    typedef enum logic {
        StIdle = 1'b0,
        StSel  = 1'b1
    } spi_state_e;

    localparam int unsigned CmdMsb  = 31;
    localparam int unsigned CmdLsb  = 24;
    localparam int unsigned AddrMsb = 23;
    localparam int unsigned AddrLsb = 16;
    localparam int unsigned DataMsb = 15;
    localparam int unsigned DataLsb = 0;

    function automatic logic [7:0] frame_cmd(input logic [31:0] frame);
        return frame[CmdMsb:CmdLsb];
    endfunction

    function automatic logic [7:0] frame_addr(input logic [31:0] frame);
        return frame[AddrMsb:AddrLsb];
    endfunction

    function automatic logic [15:0] frame_data(input logic [31:0] frame);
        return frame[DataMsb:DataLsb];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pad input, with rise/fall detection
// on the synchronised value. Reset value is chosen per line so reset causes no edge.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave_frame_rx.sv
// SPI mode-3 slave: oversampled in the CLK domain, deserialises MSB-first frames on MOSI and
// serialises a reply word on MISO. Frames are delivered as a one-cycle rx_valid strobe.
module spi_slave_frame_rx
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = FrameBitsDef,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SCK,
    input  logic                  SSEL,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  tx_taken,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned   CntW    = $clog2(FRAME_BITS);
    localparam logic [CntW-1:0] LastBit = CntW'(FRAME_BITS - 1);

    logic sck_rise, sck_fall;
    logic ssel_rise, ssel_fall;
    logic mosi_s;
    logic unused_sck_s, unused_ssel_s, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_sck (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .async_i (SCK),
        .sync_o  (unused_sck_s),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_ssel (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .async_i (SSEL),
        .sync_o  (unused_ssel_s),
        .rise_o  (ssel_rise),
        .fall_o  (ssel_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_mosi (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .async_i (MOSI),
        .sync_o  (mosi_s),
        .rise_o  (unused_mosi_rise),
        .fall_o  (unused_mosi_fall)
    );

    spi_state_e state_q, state_d;

    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [FRAME_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  miso_q, miso_d;
    logic                  rx_valid_q, tx_taken_q, frame_err_q;

    // Decoded per-cycle actions from the output process.
    logic load_tx, shift_tx, shift_rx, complete, abort, clr_cnt, clr_miso;
    logic last_bit;

    assign last_bit = (bit_cnt_q == LastBit);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ssel_fall) state_d = StSel;
            StSel:   if (ssel_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output/action decode.
    always_comb begin
        load_tx  = 1'b0;
        shift_tx = 1'b0;
        shift_rx = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        clr_cnt  = 1'b0;
        clr_miso = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ssel_fall) begin
                    load_tx = 1'b1;
                    clr_cnt = 1'b1;
                end
            end
            StSel: begin
                if (ssel_rise) begin
                    // A completing rise in the same cycle as deselect still delivers the frame.
                    clr_cnt  = 1'b1;
                    clr_miso = 1'b1;
                    if (sck_rise && last_bit) begin
                        shift_rx = 1'b1;
                        complete = 1'b1;
                    end else if (bit_cnt_q != '0) begin
                        abort = 1'b1;
                    end
                end else begin
                    if (sck_rise) begin
                        shift_rx = 1'b1;
                        complete = last_bit;
                        load_tx  = last_bit;
                    end
                    if (sck_fall) shift_tx = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_sh_d   = rx_sh_q;
        tx_sh_d   = tx_sh_q;
        rx_data_d = rx_data_q;
        miso_d    = miso_q;

        if (clr_cnt) begin
            bit_cnt_d = '0;
        end else if (shift_rx) begin
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        end

        if (shift_rx) rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], mosi_s};
        if (complete) rx_data_d = {rx_sh_q[FRAME_BITS-2:0], mosi_s};

        if (load_tx) begin
            tx_sh_d = tx_data;
        end else if (shift_tx) begin
            tx_sh_d = {tx_sh_q[FRAME_BITS-2:0], 1'b0};
        end

        if (clr_miso) begin
            miso_d = 1'b0;
        end else if (shift_tx) begin
            miso_d = tx_sh_q[FRAME_BITS-1];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_taken_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            rx_valid_q  <= complete;
            tx_taken_q  <= load_tx;
            frame_err_q <= abort;
        end
    end

    logic unused_rx_msb;
    assign unused_rx_msb = rx_sh_q[FRAME_BITS-1];

    assign MISO      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_taken  = tx_taken_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == StSel);

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// Bench for spi_slave_frame_rx: directed vector table, reset/idle sequences and randomised
// sessions checked against a bit-stream model of what the SPI master expects.
module tb_spi_slave_frame_rx;

    logic        CLK = 1'b0;
    logic        RST_N, SCK, SSEL, MOSI, MISO;
    logic [31:0] rx_data, tx_data;
    logic        rx_valid, tx_taken, frame_err, busy;

    always #5 CLK = ~CLK;

    spi_slave_frame_rx #(
        .FRAME_BITS  (32),
        .SYNC_STAGES (2)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SCK       (SCK),
        .SSEL      (SSEL),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_taken  (tx_taken),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse monitor: counts strobes, queues delivered frames, flags any strobe wider than 1 cycle.
    int          mon_valid = 0, mon_taken = 0, mon_err = 0, mon_wide = 0;
    logic [31:0] rxq[$];
    logic        pv = 1'b0, pt = 1'b0, pe = 1'b0;

    always @(negedge CLK) begin
        if (rx_valid === 1'b1) begin
            mon_valid++;
            rxq.push_back(rx_data);
        end
        if (tx_taken === 1'b1) mon_taken++;
        if (frame_err === 1'b1) mon_err++;
        if ((rx_valid && pv) || (tx_taken && pt) || (frame_err && pe)) mon_wide++;
        pv = rx_valid;
        pt = tx_taken;
        pe = frame_err;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    logic mosi_bits[0:127];
    logic miso_bits[0:127];

    // One SSEL-low session of k SCK cycles; master drives on fall, samples MISO on rise.
    task automatic run_session(input int k, input int half);
        SSEL = 1'b0;
        wait_cyc(8);
        check("busy_selected", busy, 1);
        for (int i = 0; i < k; i++) begin
            SCK  = 1'b0;
            MOSI = mosi_bits[i];
            wait_cyc(half);
            SCK          = 1'b1;
            miso_bits[i] = MISO;
            wait_cyc(half);
        end
        wait_cyc(8);
        SSEL = 1'b1;
        wait_cyc(10);
        check("busy_after_deselect", busy, 0);
        check("miso_after_deselect", MISO, 0);
    endtask

    typedef struct {
        string       name;
        logic [63:0] mosi;
        int          nbits;
        logic [31:0] tx;
        int          exp_valid;
        int          exp_err;
        int          exp_taken;
        logic [31:0] exp_first;
        logic [31:0] exp_rx;
        logic [63:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, t0, e0, q0, k, half, mism, nw;
        int forced[6];
        logic [31:0] tx, w, exp_last;
        logic [63:0] mw;

        vecs[0] = '{"single", 64'h80CC0000_00000000, 32, 32'hA5A50F0F, 1, 0, 2,
                    32'h80CC0000, 32'h80CC0000, 64'hA5A50F0F};
        vecs[1] = '{"abort10", 64'hFFC00000_00000000, 10, 32'h12345678, 0, 1, 1,
                    32'h0, 32'h80CC0000, 64'h048};
        vecs[2] = '{"b2b", 64'h12345678_9ABCDEF0, 64, 32'h0F0F1234, 2, 0, 3,
                    32'h12345678, 32'h9ABCDEF0, 64'h0F0F1234};
        vecs[3] = '{"ones", 64'hFFFFFFFF_00000000, 32, 32'h00000000, 1, 0, 2,
                    32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0};
        vecs[4] = '{"abort5", 64'hF8000000_00000000, 5, 32'hFFFFFFFF, 0, 1, 1,
                    32'h0, 32'hFFFFFFFF, 64'h1F};

        RST_N   = 1'b0;
        SCK     = 1'b1;
        SSEL    = 1'b1;
        MOSI    = 1'b0;
        tx_data = '0;
        wait_cyc(3);
        check("rst_miso", MISO, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_strobes", {rx_valid, tx_taken, frame_err}, 0);
        check("rst_busy", busy, 0);
        RST_N = 1'b1;
        wait_cyc(10);
        check("post_rst_pulses", mon_valid + mon_taken + mon_err, 0);

        // Directed vector table at SCK = CLK/32.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 64; i++) mosi_bits[i] = vecs[r].mosi[63-i];
            tx_data = vecs[r].tx;
            v0 = mon_valid; t0 = mon_taken; e0 = mon_err; q0 = rxq.size();
            run_session(vecs[r].nbits, 16);
            check({vecs[r].name, "_valid"}, 64'(mon_valid - v0), 64'(vecs[r].exp_valid));
            check({vecs[r].name, "_err"}, 64'(mon_err - e0), 64'(vecs[r].exp_err));
            check({vecs[r].name, "_taken"}, 64'(mon_taken - t0), 64'(vecs[r].exp_taken));
            check({vecs[r].name, "_rx_data"}, 64'(rx_data), 64'(vecs[r].exp_rx));
            if (vecs[r].exp_valid > 0 && rxq.size() > q0)
                check({vecs[r].name, "_first"}, 64'(rxq[q0]), 64'(vecs[r].exp_first));
            mw = '0;
            for (int i = 0; i < vecs[r].nbits && i < 32; i++) mw = {mw[62:0], miso_bits[i]};
            check({vecs[r].name, "_miso"}, mw, vecs[r].exp_miso);
        end

        // Reset in the middle of a frame, after 17 bits.
        tx_data = 32'hFFFFFFFF;
        SSEL    = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 17; i++) begin
            SCK  = 1'b0;
            MOSI = i[0];
            wait_cyc(8);
            SCK = 1'b1;
            wait_cyc(8);
        end
        SCK = 1'b0;
        wait_cyc(5);
        RST_N = 1'b0;
        #1;
        check("midrst_rx_data", rx_data, 0);
        check("midrst_miso", MISO, 0);
        check("midrst_busy", busy, 0);
        check("midrst_strobes", {rx_valid, tx_taken, frame_err}, 0);
        SSEL = 1'b1;
        SCK  = 1'b1;
        wait_cyc(3);
        v0 = mon_valid; t0 = mon_taken; e0 = mon_err;
        RST_N = 1'b1;
        wait_cyc(20);
        check("midrst_no_pulse", 64'(mon_valid - v0 + mon_taken - t0 + mon_err - e0), 0);
        w = 32'h0000FFFF;
        for (int i = 0; i < 32; i++) mosi_bits[i] = w[31-i];
        tx_data = 32'h5A5A5A5A;
        v0 = mon_valid; e0 = mon_err;
        run_session(32, 16);
        check("midrst_next_valid", 64'(mon_valid - v0), 1);
        check("midrst_next_err", 64'(mon_err - e0), 0);
        check("midrst_next_rx", rx_data, 32'h0000FFFF);
        exp_last = 32'h0000FFFF;

        // Idle noise: SCK toggling while deselected.
        v0 = mon_valid; t0 = mon_taken; e0 = mon_err;
        for (int i = 0; i < 100; i++) begin
            SCK  = ~SCK;
            MOSI = 1'($urandom);
            wait_cyc(4);
            if (i == 51) check("noise_miso_mid", MISO, 0);
        end
        check("noise_pulses", 64'(mon_valid - v0 + mon_taken - t0 + mon_err - e0), 0);
        check("noise_miso", MISO, 0);
        check("noise_busy", busy, 0);
        check("noise_rx_data", rx_data, 32'h0000FFFF);

        // Randomised sessions against the bit-stream model.
        forced = '{1, 31, 32, 33, 64, 0};
        for (int s = 0; s < 16; s++) begin
            k    = (s < 6) ? forced[s] : int'($urandom_range(1, 96));
            half = int'($urandom_range(4, 6));
            tx   = $urandom;
            for (int i = 0; i < k; i++) mosi_bits[i] = 1'($urandom);
            tx_data = tx;
            v0 = mon_valid; t0 = mon_taken; e0 = mon_err; q0 = rxq.size();
            run_session(k, half);
            nw = k / 32;
            check("rand_valid", 64'(mon_valid - v0), 64'(nw));
            check("rand_err", 64'(mon_err - e0), 64'((k % 32) != 0));
            check("rand_taken", 64'(mon_taken - t0), 64'(1 + nw));
            for (int j = 0; j < nw; j++) begin
                w = '0;
                for (int b = 0; b < 32; b++) w = {w[30:0], mosi_bits[j*32+b]};
                exp_last = w;
                if (rxq.size() > q0 + j) check("rand_word", 64'(rxq[q0+j]), 64'(w));
                else check("rand_word_missing", 64'(rxq.size()), 64'(q0 + j + 1));
            end
            check("rand_rx_data", rx_data, exp_last);
            mism = 0;
            for (int i = 0; i < k; i++) if (miso_bits[i] !== tx[31 - (i % 32)]) mism++;
            check("rand_miso_bits_wrong", 64'(mism), 0);
        end

        check("strobe_width", 64'(mon_wide), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
